// File: rtl/eq1_bist_amisha.sv
// ---------------------------------------------------------------------------
// eq1_bist_amisha
// Built-in self-test sequencer for the 1-bit equality comparator eq1_Amisha.
// A run sweeps the comparator inputs through (i0,i1) = 00,10,01,11. Each
// vector is held for HOLD_CYCLES cycles. On the last hold cycle the
// comparator output is sampled and checked against ~(i0 ^ i1). Mismatches
// are counted. A run ends with a one-cycle done pulse and a pass flag.
//
// Ports:
//   clk_amisha            in   clock, rising edge
//   rst_n_amisha          in   synchronous reset, active-low
//   start_amisha          in   launches a run when sampled high in IDLE
//   i0_amisha, i1_amisha  out  registered comparator stimulus
//   eq_amisha             in   comparator output under test
//   busy_amisha           out  high while vectors are being applied
//   done_amisha           out  single-cycle end-of-run pulse
//   pass_amisha           out  last completed run had zero mismatches
//   err_count_amisha      out  saturating mismatch count
//   first_fail_vec_amisha out  vector index of the first mismatch
// ---------------------------------------------------------------------------
module eq1_bist_amisha #(
   parameter int HOLD_CYCLES = 4,
   parameter int PASSES      = 1,
   parameter int ERR_W       = 8
) (
   input  logic             clk_amisha,
   input  logic             rst_n_amisha,
   input  logic             start_amisha,
   output logic             i0_amisha,
   output logic             i1_amisha,
   input  logic             eq_amisha,
   output logic             busy_amisha,
   output logic             done_amisha,
   output logic             pass_amisha,
   output logic [ERR_W-1:0] err_count_amisha,
   output logic [1:0]       first_fail_vec_amisha
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       vec;
   logic [1:0]       vec_next;
   logic [HW-1:0]    hold_cnt;
   logic [PW-1:0]    pass_cnt;
   logic             last_hold;
   logic             expected;
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Sample point and check. err_next already includes the mismatch of the
   // current sample, so the pass flag taken on the final vector sees the
   // complete count.
   always_comb begin
      vec_next  = vec + 2'd1;
      last_hold = (state == S_APPLY) && (hold_cnt == HOLD_LAST);
      expected  = ~(vec[0] ^ vec[1]);
      mismatch  = last_hold && (eq_amisha != expected);
      err_next  = err_count_amisha;
      if (mismatch && (err_count_amisha != {ERR_W{1'b1}})) begin
         err_next = err_count_amisha + ERR_W'(1);
      end
   end

   // Sequencer. The stimulus outputs are loaded from vec_next on the edge
   // where vec advances. After vector 3, vec_next wraps to 0. This also
   // gives the required i0/i1 = 0 when the run drops into DONE.
   always_ff @(posedge clk_amisha) begin
      if (!rst_n_amisha) begin
         state                 <= S_IDLE;
         vec                   <= 2'd0;
         hold_cnt              <= '0;
         pass_cnt              <= '0;
         i0_amisha             <= 1'b0;
         i1_amisha             <= 1'b0;
         busy_amisha           <= 1'b0;
         done_amisha           <= 1'b0;
         pass_amisha           <= 1'b0;
         err_count_amisha      <= '0;
         first_fail_vec_amisha <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               done_amisha <= 1'b0;
               i0_amisha   <= 1'b0;
               i1_amisha   <= 1'b0;
               if (start_amisha) begin
                  state                 <= S_APPLY;
                  vec                   <= 2'd0;
                  hold_cnt              <= '0;
                  pass_cnt              <= '0;
                  busy_amisha           <= 1'b1;
                  pass_amisha           <= 1'b0;
                  err_count_amisha      <= '0;
                  first_fail_vec_amisha <= 2'd0;
               end
            end
            S_APPLY: begin
               if (last_hold) begin
                  err_count_amisha <= err_next;
                  if (mismatch && (err_count_amisha == '0)) begin
                     first_fail_vec_amisha <= vec;
                  end
                  hold_cnt  <= '0;
                  vec       <= vec_next;
                  i0_amisha <= vec_next[0];
                  i1_amisha <= vec_next[1];
                  if (vec == 2'd3) begin
                     if (pass_cnt == PASS_LAST) begin
                        state       <= S_DONE;
                        busy_amisha <= 1'b0;
                        done_amisha <= 1'b1;
                        pass_amisha <= (err_next == '0);
                     end else begin
                        pass_cnt <= pass_cnt + PW'(1);
                     end
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            S_DONE: begin
               done_amisha <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/eq1_bist_amisha.md
Name: eq1_bist_amisha

Overview:
- Synthesizable built-in self-test sequencer for the 1-bit equality comparator `eq1_Amisha`.
- Drives the comparator's two inputs through all four input combinations, holds each combination for a programmable number of cycles, then samples the comparator's `eq` output.
- Checks each sample against the expected value `~(i0 ^ i1)`, counts mismatches and reports pass/fail with a start/done handshake.
- Sits beside `eq1_Amisha` in hardware, replacing the manual stimulus sweep with an on-chip checker.

Parameters:
- HOLD_CYCLES, 4, cycles each input vector is driven before `eq` is sampled; legal range is 1 or more.
- PASSES, 1, number of full 4-vector sweeps per run; legal range is 1 or more.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk_amisha  in  1  clock; all state updates on the rising edge.
- rst_n_amisha  in  1  synchronous reset, active-low.
- start_amisha  in  1  begins a run when sampled high in IDLE.
- i0_amisha  out  1  drives comparator input i0.
- i1_amisha  out  1  drives comparator input i1.
- eq_amisha  in  1  comparator output under test.
- busy_amisha  out  1  high while a run is in progress (APPLY state).
- done_amisha  out  1  single-cycle pulse at end of run.
- pass_amisha  out  1  high if the last completed run had zero mismatches.
- err_count_amisha  out  ERR_W  mismatches in the current or last run; saturating.
- first_fail_vec_amisha  out  2  vector index of the first mismatch; meaningful only when err_count_amisha != 0.

Behaviour:
- Reset (rst_n_amisha low at an edge): state IDLE; i0/i1/busy/done/pass = 0; err_count = 0; first_fail_vec = 0; all internal counters cleared.
- Reset mid-run aborts immediately with the same values; no done pulse is issued.
- Vector index `vec` (2 bits), sweep order 0,1,2,3:
  - i0_amisha = vec[0], i1_amisha = vec[1].
  - Resulting (i0,i1) sequence: 00, 10, 01, 11.
  - Expected eq per vector: 1, 0, 0, 1.
- Outputs i0/i1 are registered, and are 0 in IDLE and DONE.
- IDLE state:
  - If start = 1: go to APPLY with vec = 0, hold_cnt = 0, pass_cnt = 0.
  - Also on start: clear err_count, first_fail_vec and pass; set busy = 1.
- APPLY state:
  - i0/i1 reflect vec; hold_cnt increments each cycle.
  - On the cycle where hold_cnt == HOLD_CYCLES-1 (the last hold cycle), compare eq_amisha with the expected value, then:
    - on mismatch with err_count == 0, load first_fail_vec = vec;
    - on any mismatch, increment err_count, saturating at 2^ERR_W-1;
    - reset hold_cnt to 0 and advance vec (3 wraps to 0).
  - When vec wraps, increment pass_cnt.
  - When the final vector of sweep PASSES-1 has been checked, go to DONE.
- DONE state (one cycle):
  - busy = 0, done = 1.
  - pass = 1 if the final err_count == 0, otherwise 0.
  - Next state is IDLE.
- Result hold: pass, err_count and first_fail_vec keep their values in IDLE until the next accepted start.
- Latency: start is sampled at edge E; APPLY occupies edges E+1 through E+4·HOLD_CYCLES·PASSES; done is high in the following cycle.
- Because i0/i1 are registered, the comparator sees each vector for the full HOLD_CYCLES before sampling; HOLD_CYCLES = 1 gives one cycle of combinational settle.
- start_amisha is ignored in APPLY and DONE; a start held high continuously re-launches a new run from IDLE after each DONE.
- The error counter never wraps: once saturated it stays at its maximum value.

Test Plan:
- Correct comparator model, HOLD_CYCLES=4, PASSES=1, start pulsed at edge E → i0/i1 show 00,10,01,11 for 4 cycles each from E+1; done high exactly in cycle E+17; pass=1; err_count=0.
- eq tied to 1 → mismatches at vec 1 and 2 → err_count=2, first_fail_vec=1, pass=0.
- eq tied to 0 → mismatches at vec 0 and 3 → err_count=2, first_fail_vec=0, pass=0.
- Inverted comparator, ERR_W=2, PASSES=2 → 8 mismatches saturate err_count at 3; first_fail_vec=0; done in cycle E+33.
- Start re-pulsed during APPLY → no restart; single done at the nominal cycle. rst_n low for 1 cycle mid-run → all outputs 0, no done pulse; a new start afterwards runs cleanly with pass=1.
- Back-to-back runs: second start after a failing run → err_count/pass/first_fail_vec cleared at the second start; correct model yields pass=1.
